adel_boot_ctrl: RTL and testbench



---
 rtl/adel_pkg.sv | 17 +
 rtl/adel_imem.sv | 26 ++
 rtl/adel_boot_ctrl.sv | 146 ++++++++++++++
 tb/tb_adel_boot_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adel_pkg.sv
// Shared types and default sizing for the adel boot controller.
package adel_pkg;

   localparam int DEPTH  = 64;
   localparam int INST_W = 16;
   localparam int PC_W   = 8;
   localparam int CNT_W  = 16;

   // Controller state; encoding is visible on the state output port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } adel_state_t;

endpackage

// File: rtl/adel_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read
// port, contents deliberately not reset.
module adel_imem #(
   parameter int DEPTH  = 64,
   parameter int INST_W = 16
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [INST_W-1:0]        i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [INST_W-1:0]        o_rdata
);

   logic [INST_W-1:0] r_mem [DEPTH];

   // Write port: a word lands on the rising edge, so a same-cycle read sees the old value.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adel_boot_ctrl.sv
// Boot sequencer for the adel core: loads the instruction memory from a
// byte stream, then releases the core for a bounded number of cycles.
module adel_boot_ctrl #(
   parameter int DEPTH  = adel_pkg::DEPTH,
   parameter int INST_W = adel_pkg::INST_W,
   parameter int PC_W   = adel_pkg::PC_W,
   parameter int CNT_W  = adel_pkg::CNT_W
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   start,
   input  logic                   ld_valid,
   output logic                   ld_ready,
   input  logic [7:0]             ld_data,
   input  logic                   ld_last,
   input  logic [CNT_W-1:0]       run_limit,
   input  logic                   halt_req,
   input  logic [PC_W-1:0]        pc,
   output logic [INST_W-1:0]      inst,
   output logic                   core_nrst,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] load_count,
   output logic [CNT_W-1:0]       cycle_count,
   output logic                   err
);

   import adel_pkg::*;

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   adel_state_t      r_state;
   logic             r_phase;        // 0: expecting low byte, 1: expecting high byte
   logic [7:0]       r_hold;
   logic [AW:0]      r_load_count;
   logic [CNT_W-1:0] r_cycle_count;
   logic [CNT_W-1:0] r_run_limit;
   logic             r_err;
   logic             r_core_nrst;

   logic              w_accept;
   logic              w_room;
   logic              w_we;
   logic [INST_W-1:0] w_wdata;
   logic [AW-1:0]     w_raddr;
   logic [INST_W-1:0] w_rdata;
   logic              w_limit_hit;
   logic              w_unused_pc;

   assign w_accept    = ld_valid & (r_state == ST_LOAD);
   assign w_room      = (r_load_count != FULL);
   // A word completes on a high byte, or on a trailing low byte marked last.
   assign w_we        = w_accept & (r_phase | ld_last) & w_room;
   assign w_wdata     = r_phase ? {ld_data, r_hold} : {8'h00, ld_data};
   assign w_raddr     = pc[AW-1:0];
   assign w_unused_pc = ^pc[PC_W-1:AW];
   assign w_limit_hit = (r_run_limit != {CNT_W{1'b0}}) &&
                        (r_cycle_count == (r_run_limit - CNT_W'(1)));

   adel_imem #(
      .DEPTH  (DEPTH),
      .INST_W (INST_W)
   ) u_imem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_load_count[AW-1:0]),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Sequencer FSM with byte assembly, load/cycle counters and core reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state       <= ST_IDLE;
         r_phase       <= 1'b0;
         r_hold        <= 8'h00;
         r_load_count  <= '0;
         r_cycle_count <= '0;
         r_run_limit   <= '0;
         r_err         <= 1'b0;
         r_core_nrst   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  r_state      <= ST_LOAD;
                  r_load_count <= '0;
                  r_err        <= 1'b0;
                  r_phase      <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  if (r_phase || ld_last) begin
                     if (w_room) begin
                        r_load_count <= r_load_count + (AW+1)'(1);
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
                  if (!r_phase) begin
                     r_hold <= ld_data;
                  end
                  if (ld_last) begin
                     // Odd byte count: the half word was still written, flag it.
                     if (!r_phase) begin
                        r_err <= 1'b1;
                     end
                     r_phase       <= 1'b0;
                     r_state       <= ST_RUN;
                     r_core_nrst   <= 1'b1;
                     r_cycle_count <= '0;
                     r_run_limit   <= run_limit;
                  end else begin
                     r_phase <= ~r_phase;
                  end
               end
            end
            ST_RUN: begin
               if (r_cycle_count != {CNT_W{1'b1}}) begin
                  r_cycle_count <= r_cycle_count + CNT_W'(1);
               end
               if (halt_req || w_limit_hit) begin
                  r_state     <= ST_HALT;
                  r_core_nrst <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_core_nrst <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready    = (r_state == ST_LOAD);
   assign core_nrst   = r_core_nrst;
   assign state       = r_state;
   assign load_count  = r_load_count;
   assign cycle_count = r_cycle_count;
   assign err         = r_err;
   // Words at or beyond the load count were not written by this program.
   assign inst        = ({1'b0, w_raddr} < r_load_count) ? w_rdata : {INST_W{1'b0}};

endmodule

// File: tb/tb_adel_boot_ctrl.sv
// Directed self-checking bench for adel_boot_ctrl.
module tb_adel_boot_ctrl;

   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic        ld_valid;
   logic        ld_ready;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic [15:0] run_limit;
   logic        halt_req;
   logic [7:0]  pc;
   logic [15:0] inst;
   logic        core_nrst;
   logic [1:0]  state;
   logic [6:0]  load_count;
   logic [15:0] cycle_count;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  basic_bytes [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
   logic [15:0] basic_words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

   adel_boot_ctrl dut (
      .clk         (clk),
      .nrst        (nrst),
      .start       (start),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .run_limit   (run_limit),
      .halt_req    (halt_req),
      .pc          (pc),
      .inst        (inst),
      .core_nrst   (core_nrst),
      .state       (state),
      .load_count  (load_count),
      .cycle_count (cycle_count),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      ld_data  = d;
      ld_last  = last;
      ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = 8'hEE;
   endtask

   task automatic wait_halt(input string tag);
      int k;
      k = 0;
      while (state != 2'd3 && k < 200) begin
         tick();
         k++;
      end
      n_checks++;
      if (state !== 2'd3) begin
         n_fail++;
         $display("FAIL %s_halt_timeout: state=%0d expected 3", tag, state);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
      run_limit = 16'd0; halt_req = 1'b0; pc = 8'd0;
      tick(); tick();
      n_checks++;
      if ({state, core_nrst, ld_ready, load_count, cycle_count, err, inst} !==
          {2'd0, 1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_values: state=%0d core_nrst=%b ld_ready=%b load_count=%0d cycle_count=%0d err=%b inst=%h expected all zero",
                  state, core_nrst, ld_ready, load_count, cycle_count, err, inst);
      end
      nrst = 1'b1;
      tick();
      n_checks++;
      if (state !== 2'd0 || ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_hold: state=%0d ld_ready=%b expected 0 0", state, ld_ready);
      end
   endtask

   task automatic test_basic_load_run();
      int hi;
      run_limit = 16'd5;
      do_start();
      n_checks++;
      if (state !== 2'd1 || ld_ready !== 1'b1 || core_nrst !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_enter_load: state=%0d ld_ready=%b core_nrst=%b expected 1 1 0", state, ld_ready, core_nrst);
      end
      for (int i = 0; i < 8; i++) send_byte(basic_bytes[i], (i == 7));
      n_checks++;
      if (state !== 2'd2 || load_count !== 7'd4 || core_nrst !== 1'b1 || cycle_count !== 16'd0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_enter_run: state=%0d load_count=%0d core_nrst=%b cycle_count=%0d err=%b expected 2 4 1 0 0",
                  state, load_count, core_nrst, cycle_count, err);
      end
      pc = 8'd1; #1;
      n_checks++;
      if (inst !== 16'h5678) begin n_fail++; $display("FAIL basic_pc1: inst=%h expected 5678", inst); end
      pc = 8'd4; #1;
      n_checks++;
      if (inst !== 16'h0000) begin n_fail++; $display("FAIL basic_pc4_unloaded: inst=%h expected 0000", inst); end
      pc = 8'h41; #1;
      n_checks++;
      if (inst !== 16'h5678) begin n_fail++; $display("FAIL basic_pc41_wrap: inst=%h expected 5678", inst); end
      pc = 8'd3; #1;
      n_checks++;
      if (inst !== 16'hDEF0) begin n_fail++; $display("FAIL basic_pc3: inst=%h expected def0", inst); end
      // run_limit changes after entry must be ignored
      run_limit = 16'd50;
      hi = 1;
      tick(); tick();
      n_checks++;
      if (cycle_count !== 16'd2) begin n_fail++; $display("FAIL basic_cycle_count: cycle_count=%0d expected 2", cycle_count); end
      hi = hi + 2;
      for (int k = 0; k < 20 && core_nrst; k++) begin
         tick();
         if (core_nrst) hi++;
      end
      n_checks++;
      if (hi !== 5 || state !== 2'd3 || core_nrst !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_run_length: high_cycles=%0d state=%0d core_nrst=%b expected 5 3 0", hi, state, core_nrst);
      end
   endtask

   task automatic test_back_to_back_backpressure();
      run_limit = 16'd4;
      do_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(basic_bytes[i], (i == 7));
         if (i != 7) begin
            ld_data = 8'hA5; ld_last = 1'b1;   // garbage while invalid
            tick();
            ld_last = 1'b0;
         end
      end
      n_checks++;
      if (state !== 2'd2 || load_count !== 7'd4 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_enter_run: state=%0d load_count=%0d err=%b expected 2 4 0", state, load_count, err);
      end
      for (int a = 0; a < 4; a++) begin
         pc = 8'(a); #1;
         n_checks++;
         if (inst !== basic_words[a]) begin
            n_fail++;
            $display("FAIL bp_image_%0d: inst=%h expected %h", a, inst, basic_words[a]);
         end
      end
      wait_halt("bp");
   endtask

   task automatic test_odd_length();
      run_limit = 16'd3;
      do_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      n_checks++;
      if (state !== 2'd2 || load_count !== 7'd2 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL odd_status: state=%0d load_count=%0d err=%b expected 2 2 1", state, load_count, err);
      end
      pc = 8'd0; #1;
      n_checks++;
      if (inst !== 16'h2211) begin n_fail++; $display("FAIL odd_word0: inst=%h expected 2211", inst); end
      pc = 8'd1; #1;
      n_checks++;
      if (inst !== 16'h0033) begin n_fail++; $display("FAIL odd_word1: inst=%h expected 0033", inst); end
      wait_halt("odd");
   endtask

   task automatic test_overflow();
      run_limit = 16'd2;
      do_start();
      n_checks++;
      if (err !== 1'b0 || load_count !== 7'd0) begin
         n_fail++;
         $display("FAIL ovf_start_clear: err=%b load_count=%0d expected 0 0", err, load_count);
      end
      for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0);
      n_checks++;
      if (load_count !== 7'd64 || err !== 1'b0 || state !== 2'd1) begin
         n_fail++;
         $display("FAIL ovf_full: load_count=%0d err=%b state=%0d expected 64 0 1", load_count, err, state);
      end
      send_byte(8'd128, 1'b0);
      send_byte(8'd129, 1'b1);
      n_checks++;
      if (load_count !== 7'd64 || err !== 1'b1 || state !== 2'd2) begin
         n_fail++;
         $display("FAIL ovf_status: load_count=%0d err=%b state=%0d expected 64 1 2", load_count, err, state);
      end
      pc = 8'd63; #1;
      n_checks++;
      if (inst !== 16'h7F7E) begin n_fail++; $display("FAIL ovf_word63: inst=%h expected 7f7e", inst); end
      pc = 8'd0; #1;
      n_checks++;
      if (inst !== 16'h0100) begin n_fail++; $display("FAIL ovf_word0_kept: inst=%h expected 0100", inst); end
      wait_halt("ovf");
   endtask

   task automatic test_halt_req();
      int k;
      run_limit = 16'd0;
      do_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b1);
      run_limit = 16'd3;
      k = 0;
      while (cycle_count != 16'd10 && k < 50) begin tick(); k++; end
      n_checks++;
      if (cycle_count !== 16'd10 || core_nrst !== 1'b1 || state !== 2'd2) begin
         n_fail++;
         $display("FAIL halt_unlimited_run: cycle_count=%0d core_nrst=%b state=%0d expected 10 1 2", cycle_count, core_nrst, state);
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_checks++;
      if (state !== 2'd3 || core_nrst !== 1'b0 || (cycle_count !== 16'd10 && cycle_count !== 16'd11) || err !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_req_stop: state=%0d core_nrst=%b cycle_count=%0d err=%b expected 3 0 10/11 1", state, core_nrst, cycle_count, err);
      end
      halt_req = 1'b1;
      do_start();
      halt_req = 1'b0;
      n_checks++;
      if (state !== 2'd1 || load_count !== 7'd0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_restart: state=%0d load_count=%0d err=%b expected 1 0 0", state, load_count, err);
      end
   endtask

   task automatic test_async_reset();
      // still in LOAD from the previous task
      for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 1'b0);
      n_checks++;
      if (load_count !== 7'd3 || state !== 2'd1) begin
         n_fail++;
         $display("FAIL arst_preload: load_count=%0d state=%0d expected 3 1", load_count, state);
      end
      #2 nrst = 1'b0;
      #1;
      n_checks++;
      if (state !== 2'd0 || core_nrst !== 1'b0 || ld_ready !== 1'b0 || load_count !== 7'd0) begin
         n_fail++;
         $display("FAIL arst_load: state=%0d core_nrst=%b ld_ready=%b load_count=%0d expected 0 0 0 0", state, core_nrst, ld_ready, load_count);
      end
      for (int a = 0; a < 4; a++) begin
         pc = 8'(a); #1;
         n_checks++;
         if (inst !== 16'h0000) begin n_fail++; $display("FAIL arst_inst_%0d: inst=%h expected 0000", a, inst); end
      end
      tick();
      nrst = 1'b1;
      run_limit = 16'd0;
      do_start();
      send_byte(8'h55, 1'b0);
      send_byte(8'hAA, 1'b1);
      tick();
      #2 nrst = 1'b0;
      #1;
      n_checks++;
      if (core_nrst !== 1'b0 || state !== 2'd0 || cycle_count !== 16'd0) begin
         n_fail++;
         $display("FAIL arst_run: core_nrst=%b state=%0d cycle_count=%0d expected 0 0 0", core_nrst, state, cycle_count);
      end
      tick();
      nrst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_load_run();
      test_back_to_back_backpressure();
      test_odd_length();
      test_overflow();
      test_halt_req();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
